// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU front end: data width, ALU function codes
// and the issue controller's state encoding.
package alu_defs_pkg;

  localparam int DW = 16;

  localparam logic [3:0] FUNC_PASSB = 4'b0000;
  localparam logic [3:0] FUNC_ADD   = 4'b0001;
  localparam logic [3:0] FUNC_SUB   = 4'b0010;
  localparam logic [3:0] FUNC_AND   = 4'b0011;
  localparam logic [3:0] FUNC_OR    = 4'b0100;
  localparam logic [3:0] FUNC_SHL   = 4'b0101;
  localparam logic [3:0] FUNC_SHR   = 4'b0110;
  localparam logic [3:0] FUNC_MUL   = 4'b0111;
  localparam logic [3:0] FUNC_MAX   = 4'b1000;
  localparam logic [3:0] FUNC_SRA   = 4'b1001;
  localparam logic [3:0] FUNC_XOR   = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two combinational operand read ports, one
// combinational debug read port and a single synchronous write port.
// Synchronous reset clears every register.
module alu_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic [$clog2(NREG)-1:0] raddr_a_i,
  output logic [DW-1:0]           rdata_a_o,
  input  logic [$clog2(NREG)-1:0] raddr_b_i,
  output logic [DW-1:0]           rdata_b_o,
  input  logic [$clog2(NREG)-1:0] dbg_addr_i,
  output logic [DW-1:0]           dbg_data_o
);

  logic [DW-1:0] regs_q [NREG];

  // Clear all registers on reset, otherwise write the addressed entry when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 16-bit ALU. Accepts one instruction at a
// time, reads operands from the local register file, pulses the ALU enable
// for one cycle, waits for the registered result and writes it back.
// A bounded wait flags a sticky timeout if the ALU never answers.
module alu_issue_ctrl #(
  parameter int DW      = 16,
  parameter int NREG    = 8,
  parameter int TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_valid,
  output logic                    inst_ready,
  input  logic [3:0]              inst_func,
  input  logic [$clog2(NREG)-1:0] inst_rd,
  input  logic [$clog2(NREG)-1:0] inst_rs,
  input  logic [$clog2(NREG)-1:0] inst_rt,
  input  logic                    inst_use_imm,
  input  logic [DW-1:0]           inst_imm,
  output logic                    alu_en_in,
  output logic [3:0]              alu_func,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  input  logic                    alu_en_out,
  input  logic [DW-1:0]           alu_out,
  output logic                    done,
  output logic [DW-1:0]           done_data,
  output logic                    timeout_err,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
);

  import alu_defs_pkg::*;

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [3:0]      func_q, func_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   done_data_q, done_data_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rdata_a, rdata_b;
  logic            wr_en;

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wr_en),
    .waddr_i    (rd_q),
    .wdata_i    (alu_out),
    .raddr_a_i  (inst_rs),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (inst_rt),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Accept only while idle; reset forces ready low even in IDLE
  assign inst_ready  = (state_q == ST_IDLE) && !rst;
  assign alu_en_in   = (state_q == ST_ISSUE);
  assign alu_func    = func_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign done        = (state_q == ST_DONE);
  assign done_data   = done_data_q;
  assign timeout_err = timeout_q;

  // Next-state logic: latch the instruction on accept, count WAIT cycles, write back on result
  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    done_data_d = done_data_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inst_valid && inst_ready) begin
          state_d = ST_ISSUE;
          func_d  = inst_func;
          rd_d    = inst_rd;
          a_d     = rdata_a;
          b_d     = inst_use_imm ? inst_imm : rdata_b;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (alu_en_out) begin
          wr_en       = 1'b1;
          done_data_d = alu_out;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      func_q      <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      done_data_q <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      done_data_q <= done_data_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural registered ALU
// and a scoreboard of expected writebacks.
module tb_alu_issue_ctrl;

  import alu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [3:0]  inst_func;
  logic [2:0]  inst_rd, inst_rs, inst_rt;
  logic        inst_use_imm;
  logic [15:0] inst_imm;
  logic        alu_en_in;
  logic [3:0]  alu_func;
  logic [15:0] alu_a, alu_b;
  logic        alu_en_out;
  logic [15:0] alu_out;
  logic        done;
  logic [15:0] done_data;
  logic        timeout_err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] regModel [8];
  logic [15:0] expQ [$];
  logic [2:0]  rdQ [$];

  logic        aluMute  = 1'b0;
  logic        spurEn   = 1'b0;
  logic [15:0] spurData = 16'h0000;
  logic        aluValid = 1'b0;
  logic [15:0] aluRes   = 16'h0000;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(16), .NREG(8), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_func    (inst_func),
    .inst_rd      (inst_rd),
    .inst_rs      (inst_rs),
    .inst_rt      (inst_rt),
    .inst_use_imm (inst_use_imm),
    .inst_imm     (inst_imm),
    .alu_en_in    (alu_en_in),
    .alu_func     (alu_func),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_en_out   (alu_en_out),
    .alu_out      (alu_out),
    .done         (done),
    .done_data    (done_data),
    .timeout_err  (timeout_err),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Reference ALU behaviour used both by the responder and for expectations
  function automatic logic [15:0] aluRef(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      FUNC_PASSB: return b;
      FUNC_ADD:   return a + b;
      FUNC_SUB:   return a - b;
      FUNC_AND:   return a & b;
      FUNC_OR:    return a | b;
      FUNC_SHL:   return a << b[3:0];
      FUNC_SHR:   return a >> b[3:0];
      FUNC_MUL:   return a * b;
      FUNC_MAX:   return (a > b) ? a : b;
      FUNC_SRA:   return $unsigned($signed(a) >>> b[3:0]);
      FUNC_XOR:   return a ^ b;
      default:    return 16'h0000;
    endcase
  endfunction

  // Registered ALU responder: result valid one cycle after the issue pulse
  always @(posedge clk) begin
    aluValid <= alu_en_in && !aluMute;
    aluRes   <= aluRef(alu_func, alu_a, alu_b);
  end

  assign alu_en_out = aluValid | spurEn;
  assign alu_out    = spurEn ? spurData : aluRes;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checkOutput($sformatf("%s_r%0d", tag, i), {16'h0, dbg_data}, {16'h0, regModel[i]});
    end
  endtask

  // Drive one instruction (called at a negedge), check the issue cycle and
  // follow it to completion or timeout. inst_valid is left high on completion.
  task automatic applyStimulus(input logic [3:0] f, input logic [2:0] rd, input logic [2:0] rs,
                               input logic [2:0] rt, input logic useImm, input logic [15:0] imm,
                               input bit expectTimeout, output logic [15:0] result,
                               output longint acceptTime);
    logic [15:0] ea, eb, er, popped;
    logic [2:0]  popRd;
    int          n;
    bit          sawDone;
    result       = 16'hxxxx;
    acceptTime   = 0;
    inst_func    = f;
    inst_rd      = rd;
    inst_rs      = rs;
    inst_rt      = rt;
    inst_use_imm = useImm;
    inst_imm     = imm;
    inst_valid   = 1'b1;
    n = 0;
    while (inst_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (inst_ready !== 1'b1) begin
      checkOutput("accept_bound", {31'h0, inst_ready}, 32'h1);
      inst_valid = 1'b0;
      return;
    end
    ea = regModel[rs];
    eb = useImm ? imm : regModel[rt];
    er = aluRef(f, ea, eb);
    if (!expectTimeout) begin
      expQ.push_back(er);
      rdQ.push_back(rd);
    end
    @(posedge clk);
    acceptTime = $time;
    #1;
    checkOutput("issue_en",    {31'h0, alu_en_in}, 32'h1);
    checkOutput("issue_func",  {28'h0, alu_func}, {28'h0, f});
    checkOutput("issue_a",     {16'h0, alu_a}, {16'h0, ea});
    checkOutput("issue_b",     {16'h0, alu_b}, {16'h0, eb});
    checkOutput("ready_busy",  {31'h0, inst_ready}, 32'h0);
    n = 0;
    sawDone = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        sawDone = 1'b1;
        break;
      end
      if (inst_ready === 1'b1) break;
    end
    if (expectTimeout) begin
      inst_valid = 1'b0;
      checkOutput("to_no_done", {31'h0, sawDone}, 32'h0);
      checkOutput("to_latency", n, 32'd10);
      checkOutput("to_flag",    {31'h0, timeout_err}, 32'h1);
      result = regModel[rd];
    end else begin
      checkOutput("done_seen",    {31'h0, sawDone}, 32'h1);
      checkOutput("done_latency", n, 32'd3);
      if (sawDone && expQ.size() > 0) begin
        popped = expQ.pop_front();
        popRd  = rdQ.pop_front();
        checkOutput("done_data", {16'h0, done_data}, {16'h0, popped});
        regModel[popRd] = popped;
        dbg_addr = popRd;
        #1;
        checkOutput("dbg_wb", {16'h0, dbg_data}, {16'h0, popped});
        result = done_data;
      end
    end
  endtask

  initial begin
    logic [15:0] res, res2;
    longint      t1, t2;
    rst          = 1'b1;
    inst_valid   = 1'b0;
    inst_func    = 4'h0;
    inst_rd      = 3'd0;
    inst_rs      = 3'd0;
    inst_rt      = 3'd0;
    inst_use_imm = 1'b0;
    inst_imm     = 16'h0;
    dbg_addr     = 3'd0;
    for (int i = 0; i < 8; i++) regModel[i] = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ready",   {31'h0, inst_ready}, 32'h0);
    checkOutput("rst_en",      {31'h0, alu_en_in}, 32'h0);
    checkOutput("rst_done",    {31'h0, done}, 32'h0);
    checkOutput("rst_ddata",   {16'h0, done_data}, 32'h0);
    checkOutput("rst_to",      {31'h0, timeout_err}, 32'h0);
    checkOutput("rst_a",       {16'h0, alu_a}, 32'h0);
    checkOutput("rst_b",       {16'h0, alu_b}, 32'h0);
    checkOutput("rst_func",    {28'h0, alu_func}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready",  {31'h0, inst_ready}, 32'h1);
    checkAllRegs("rst");

    // Load operands, then add / sub / mul
    applyStimulus(FUNC_PASSB, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0003, 1'b0, res, t1);
    applyStimulus(FUNC_PASSB, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b0, res, t1);
    applyStimulus(FUNC_ADD,   3'd3, 3'd1, 3'd2, 1'b0, 16'hFFFF, 1'b0, res, t1);
    checkOutput("add_result", {16'h0, res}, 32'h0008);
    applyStimulus(FUNC_SUB,   3'd4, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, res, t1);
    checkOutput("sub_wrap", {16'h0, res}, 32'hFFFE);
    applyStimulus(FUNC_PASSB, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0100, 1'b0, res, t1);
    applyStimulus(FUNC_MUL,   3'd5, 3'd1, 3'd0, 1'b1, 16'h0100, 1'b0, res, t1);
    checkOutput("mul_trunc", {16'h0, res}, 32'h0000);

    // Back-to-back with valid held high; second reads the first's destination
    applyStimulus(FUNC_ADD, 3'd6, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b0, res, t1);
    applyStimulus(FUNC_ADD, 3'd7, 3'd6, 3'd2, 1'b0, 16'h0000, 1'b0, res2, t2);
    checkOutput("b2b_gap",    32'((t2 - t1) / 10), 32'd4);
    checkOutput("b2b_result", {16'h0, res2}, 32'h000F);
    applyStimulus(4'hF, 3'd3, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b0, res, t1);
    checkOutput("undef_zero", {16'h0, res}, 32'h0000);
    inst_valid = 1'b0;
    @(negedge clk);
    checkAllRegs("mid");

    // ALU never answers: timeout, no writeback, sticky flag
    aluMute = 1'b1;
    applyStimulus(FUNC_PASSB, 3'd6, 3'd0, 3'd0, 1'b1, 16'h7777, 1'b1, res, t1);
    aluMute = 1'b0;
    dbg_addr = 3'd6;
    #1;
    checkOutput("to_r6_kept", {16'h0, dbg_data}, 32'h000A);
    @(negedge clk);
    applyStimulus(FUNC_PASSB, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1111, 1'b0, res, t1);
    inst_valid = 1'b0;
    checkOutput("to_sticky", {31'h0, timeout_err}, 32'h1);

    // Reset while waiting on the ALU
    @(negedge clk);
    aluMute      = 1'b1;
    inst_func    = FUNC_PASSB;
    inst_rd      = 3'd2;
    inst_use_imm = 1'b1;
    inst_imm     = 16'h9999;
    inst_valid   = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wrst_en",   {31'h0, alu_en_in}, 32'h0);
    checkOutput("wrst_to",   {31'h0, timeout_err}, 32'h0);
    checkOutput("wrst_done", {31'h0, done}, 32'h0);
    for (int i = 0; i < 8; i++) regModel[i] = 16'h0;
    expQ.delete();
    rdQ.delete();
    checkAllRegs("wrst");
    @(negedge clk);
    rst      = 1'b0;
    aluMute  = 1'b0;
    spurEn   = 1'b1;
    spurData = 16'h1234;
    #1;
    checkOutput("wrst_ready", {31'h0, inst_ready}, 32'h1);
    @(negedge clk);
    spurEn = 1'b0;
    checkOutput("late_done", {31'h0, done}, 32'h0);
    checkAllRegs("late");

    // Spurious result valid while idle
    applyStimulus(FUNC_PASSB, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0055, 1'b0, res, t1);
    inst_valid = 1'b0;
    @(negedge clk);
    spurEn   = 1'b1;
    spurData = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("spur_done", {31'h0, done}, 32'h0);
    end
    spurEn = 1'b0;
    @(negedge clk);
    checkOutput("spur_done_after", {31'h0, done}, 32'h0);
    checkAllRegs("spur");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
